// File: rtl/eth_tx_sched.sv
// Frame scheduler for the shared 10BASE-T transmitter.
// Round-robin grant, inter-frame gap, link pulses and frame watchdog.
module eth_tx_sched #(
  parameter int IFG_BITS     = 96,
  parameter int NLP_PERIOD   = 160000,
  parameter int BUSY_TIMEOUT = 12500,
  parameter int ACK_TICKS    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic eth_clk_en,
  input  logic req_audio,
  input  logic req_beacon,
  input  logic tx_busy,
  output logic tx_start,
  output logic tx_sel,
  output logic gnt_audio,
  output logic gnt_beacon,
  output logic tx_nlp,
  output logic timeout_err
);

  localparam int NW = $clog2(NLP_PERIOD);
  localparam int M1 = (IFG_BITS > ACK_TICKS) ? IFG_BITS : ACK_TICKS;
  localparam int CMAX = (BUSY_TIMEOUT > M1) ? BUSY_TIMEOUT : M1;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [NW-1:0] NLP_LAST = NW'(NLP_PERIOD - 1);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TICKS - 1);
  localparam logic [CW-1:0] BSY_LAST = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ACK   = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] nlp_cnt_q, nlp_cnt_d;
  logic          tx_start_q, tx_start_d;
  logic          tx_sel_q, tx_sel_d;
  logic          gnt_audio_q, gnt_audio_d;
  logic          gnt_beacon_q, gnt_beacon_d;
  logic          tx_nlp_q, tx_nlp_d;
  logic          err_q, err_d;
  logic          last_q, last_d;
  logic          any_req;
  logic          pick_beacon;

  // last_q = 1 means beacon was granted most recently
  assign any_req     = req_audio | req_beacon;
  assign pick_beacon = req_beacon & (~req_audio | ~last_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nlp_cnt_d    = nlp_cnt_q;
    tx_start_d   = tx_start_q;
    tx_sel_d     = tx_sel_q;
    gnt_audio_d  = 1'b0;
    gnt_beacon_d = 1'b0;
    tx_nlp_d     = tx_nlp_q;
    err_d        = err_q;
    last_d       = last_q;
    if (eth_clk_en) begin
      tx_nlp_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            tx_sel_d     = pick_beacon;
            last_d       = pick_beacon;
            gnt_beacon_d = pick_beacon;
            gnt_audio_d  = ~pick_beacon;
            tx_start_d   = 1'b1;
            nlp_cnt_d    = '0;
            state_d      = S_START;
          end else if (nlp_cnt_q == NLP_LAST) begin
            tx_nlp_d  = 1'b1;
            nlp_cnt_d = '0;
          end else begin
            nlp_cnt_d = nlp_cnt_q + 1'b1;
          end
        end
        S_START: begin
          tx_start_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_ACK;
        end
        S_ACK: begin
          if (tx_busy) begin
            cnt_d   = '0;
            state_d = S_SEND;
          end else if (cnt_q == ACK_LAST) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            cnt_d   = '0;
            state_d = S_GAP;
          end else if (cnt_q == BSY_LAST) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          // any busy tick restarts the quiet-line count
          if (tx_busy) begin
            cnt_d = '0;
          end else if (cnt_q == IFG_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      nlp_cnt_q    <= '0;
      tx_start_q   <= 1'b0;
      tx_sel_q     <= 1'b0;
      gnt_audio_q  <= 1'b0;
      gnt_beacon_q <= 1'b0;
      tx_nlp_q     <= 1'b0;
      err_q        <= 1'b0;
      last_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nlp_cnt_q    <= nlp_cnt_d;
      tx_start_q   <= tx_start_d;
      tx_sel_q     <= tx_sel_d;
      gnt_audio_q  <= gnt_audio_d;
      gnt_beacon_q <= gnt_beacon_d;
      tx_nlp_q     <= tx_nlp_d;
      err_q        <= err_d;
      last_q       <= last_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_sel      = tx_sel_q;
  assign gnt_audio   = gnt_audio_q;
  assign gnt_beacon  = gnt_beacon_q;
  assign tx_nlp      = tx_nlp_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched with a grant scoreboard.
// Tick every 2nd clk; small parameters for short frames.
module tb_eth_tx_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic eth_clk_en = 1'b0;
  logic req_audio = 1'b0;
  logic req_beacon = 1'b0;
  logic tx_busy = 1'b0;
  logic tx_start, tx_sel, gnt_audio, gnt_beacon;
  logic tx_nlp, timeout_err;

  int vectors = 0;
  int miscompares = 0;
  logic sb_q[$];

  eth_tx_sched #(
    .IFG_BITS(8),
    .NLP_PERIOD(64),
    .BUSY_TIMEOUT(32),
    .ACK_TICKS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .eth_clk_en(eth_clk_en),
    .req_audio(req_audio),
    .req_beacon(req_beacon),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_sel(tx_sel),
    .gnt_audio(gnt_audio),
    .gnt_beacon(gnt_beacon),
    .tx_nlp(tx_nlp),
    .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    eth_clk_en = ~eth_clk_en;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    while (!eth_clk_en) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (10) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_busy = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_outs",
        {26'b0, tx_start, tx_sel, gnt_audio,
         gnt_beacon, tx_nlp, timeout_err}, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int budget, output int n);
    bit   seen;
    logic e;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      tick();
      n++;
      if (gnt_audio | gnt_beacon) seen = 1'b1;
    end
    chk("grant_seen", {31'b0, seen}, 1);
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty: grant with no expected entry");
    end else begin
      e = sb_q.pop_front();
      chk("grant_src", {30'b0, gnt_beacon, gnt_audio},
          e ? 32'd2 : 32'd1);
      chk("grant_sel", {31'b0, tx_sel}, {31'b0, e});
      chk("grant_start", {31'b0, tx_start}, 1);
    end
    @(posedge clk);
    #1;
    chk("grant_pulse", {30'b0, gnt_beacon, gnt_audio}, 0);
    chk("start_hold", {31'b0, tx_start}, 1);
  endtask

  task automatic frame(input int len, input logic sel);
    tick();
    chk("start_width", {31'b0, tx_start}, 0);
    chk("sel_frame", {31'b0, tx_sel}, {31'b0, sel});
    tx_busy = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick();
      chk("sel_frame", {31'b0, tx_sel}, {31'b0, sel});
      chk("no_start", {31'b0, tx_start}, 0);
    end
    tx_busy = 1'b0;
  endtask

  initial begin
    int n;
    int hits;

    // idle link pulses and their shift after a frame
    do_reset();
    for (int k = 1; k <= 99; k++) begin
      tick();
      chk("nlp_idle", {31'b0, tx_nlp}, {31'b0, k == 64});
    end
    req_audio = 1'b1;
    sb_q.push_back(1'b0);
    wait_grant(2, n);
    chk("nlp_req_lat", n, 1);
    req_audio = 1'b0;
    frame(5, 1'b0);
    for (int k = 1; k <= 73; k++) begin
      tick();
      chk("nlp_shift", {31'b0, tx_nlp}, {31'b0, k == 73});
    end
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk("nlp_period", {31'b0, tx_nlp}, {31'b0, k == 64});
    end

    // tie round robin from reset: audio first
    do_reset();
    req_audio = 1'b1;
    req_beacon = 1'b1;
    sb_q.push_back(1'b0);
    sb_q.push_back(1'b1);
    sb_q.push_back(1'b0);
    sb_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_grant(20, n);
      if (i == 3) begin
        req_audio = 1'b0;
        req_beacon = 1'b0;
      end
      frame(4, logic'(i % 2));
    end
    settle();

    // single audio source and inter-frame spacing
    req_audio = 1'b1;
    sb_q.push_back(1'b0);
    wait_grant(4, n);
    chk("single_lat", n, 1);
    frame(20, 1'b0);
    sb_q.push_back(1'b0);
    wait_grant(20, n);
    chk("ifg_spacing", n, 10);
    req_audio = 1'b0;
    frame(3, 1'b0);
    settle();
    chk("err_clear", {31'b0, timeout_err}, 0);

    // no acknowledge from the transmitter
    req_audio = 1'b1;
    sb_q.push_back(1'b0);
    wait_grant(4, n);
    tick();
    chk("noack_start", {31'b0, tx_start}, 0);
    repeat (3) begin
      tick();
      chk("noack_early", {31'b0, timeout_err}, 0);
    end
    tick();
    chk("noack_err", {31'b0, timeout_err}, 1);
    sb_q.push_back(1'b0);
    wait_grant(20, n);
    chk("noack_regrant", n, 9);
    req_audio = 1'b0;
    frame(3, 1'b0);
    settle();
    chk("err_sticky", {31'b0, timeout_err}, 1);

    // stuck busy
    do_reset();
    req_beacon = 1'b1;
    sb_q.push_back(1'b1);
    wait_grant(4, n);
    tick();
    tx_busy = 1'b1;
    tick();
    repeat (31) begin
      tick();
      chk("stuck_early", {31'b0, timeout_err}, 0);
    end
    tick();
    chk("stuck_err", {31'b0, timeout_err}, 1);
    hits = 0;
    repeat (20) begin
      tick();
      if (tx_start | gnt_audio | gnt_beacon) hits++;
    end
    chk("gap_hold", hits, 0);
    tx_busy = 1'b0;
    sb_q.push_back(1'b1);
    wait_grant(20, n);
    chk("stuck_regrant", n, 9);
    req_beacon = 1'b0;
    frame(3, 1'b1);
    settle();

    // reset in the middle of a frame
    req_audio = 1'b1;
    sb_q.push_back(1'b0);
    wait_grant(4, n);
    tick();
    tx_busy = 1'b1;
    repeat (8) tick();
    do_reset();
    sb_q.push_back(1'b0);
    wait_grant(4, n);
    chk("post_rst_lat", n, 1);
    req_audio = 1'b0;
    frame(3, 1'b0);
    settle();

    chk("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
